// File: rtl/io_evt_pkg.sv
// Shared widths, types and defaults for the IO event queue.
package io_evt_pkg;

  localparam int unsigned EVT_ID_WIDTH  = 8;
  localparam int unsigned DEFAULT_DEPTH = 8;

  typedef logic [EVT_ID_WIDTH-1:0] evt_id_t;

endpackage

// File: rtl/io_evt_fifo.sv
// Synchronous event-ID FIFO with a registered head/valid view of the oldest entry.
module io_evt_fifo
  import io_evt_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  evt_id_t          din,
  input  logic             pop,
  output logic             valid,
  output evt_id_t          head,
  output logic [CNT_W-1:0] count
);

  evt_id_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic             valid_q;
  evt_id_t          head_q;
  evt_id_t          head_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok    = push && (count_q < CNT_W'(DEPTH));
  assign pop_ok     = pop && valid_q;
  assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

  // Storage carries no reset; only the occupancy state does.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  // Head follows the entry that becomes oldest after this edge, bypassing din when it lands in an empty slot.
  always_comb begin
    count_nxt = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    head_nxt  = head_q;
    if (count_nxt == '0) begin
      head_nxt = '0;
    end else if (pop_ok) begin
      head_nxt = (count_q > CNT_W'(1)) ? mem[rd_ptr_inc] : din;
    end else if (count_q == '0) begin
      head_nxt = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_inc;
      count_q <= count_nxt;
      valid_q <= (count_nxt != '0);
      head_q  <= head_nxt;
    end
  end

  assign valid = valid_q;
  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/io_event_queue.sv
// Peripheral event collector: per-source pending bits, round-robin arbiter, FIFO toward the uDMA.
// Optional dropped-event counter (ovf_cnt_o/ovf_clr_i) is built when EVT_OVF_CNT_EN is defined.
module io_event_queue
  import io_evt_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 32,
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter logic [7:0]  SRC_ID_BASE = 8'd0
) (
  input  logic               sys_clk_i,
  input  logic               sys_rst_i,
  input  logic [NUM_SRC-1:0] evt_src_i,
  output logic               event_valid_o,
  output logic [7:0]         event_data_o,
  input  logic               event_ready_i,
  output logic               overflow_o
`ifdef EVT_OVF_CNT_EN
  ,
  output logic [15:0]        ovf_cnt_o,
  input  logic               ovf_clr_i
`endif
);

  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] gnt_vec;
  logic [NUM_SRC-1:0] drop;
  logic [SRC_W-1:0]   rr_q;
  logic [SRC_W-1:0]   gnt_idx;
  logic               gnt_found;
  logic               push;
  evt_id_t            push_id;
  logic [CNT_W-1:0]   fifo_count;
  logic               overflow_q;

  function automatic int unsigned wrap_src(input int unsigned v);
    return (v >= NUM_SRC) ? v - NUM_SRC : v;
  endfunction

  // First pending source at or above the round-robin pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!gnt_found && pending_q[SRC_W'(wrap_src(32'(rr_q) + i))]) begin
        gnt_found = 1'b1;
        gnt_idx   = SRC_W'(wrap_src(32'(rr_q) + i));
      end
    end
  end

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign push    = gnt_found && (fifo_count < CNT_W'(DEPTH));
  assign gnt_vec = push ? (NUM_SRC'(1) << gnt_idx) : '0;
  assign drop    = evt_src_i & pending_q & ~gnt_vec;
  assign push_id = SRC_ID_BASE + EVT_ID_WIDTH'(gnt_idx);

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      pending_q  <= '0;
      rr_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= (pending_q & ~gnt_vec) | evt_src_i;
      overflow_q <= |drop;
      if (push) rr_q <= SRC_W'(wrap_src(32'(gnt_idx) + 1));
    end
  end

  io_evt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (sys_clk_i),
    .rst   (sys_rst_i),
    .push  (push),
    .din   (push_id),
    .pop   (event_ready_i),
    .valid (event_valid_o),
    .head  (event_data_o),
    .count (fifo_count)
  );

  assign overflow_o = overflow_q;

`ifdef EVT_OVF_CNT_EN
  localparam int unsigned DROP_W = $clog2(NUM_SRC + 1);

  logic [DROP_W-1:0] drop_num;
  logic [16:0]       ovf_sum;
  logic [15:0]       ovf_cnt_q;

  always_comb begin
    drop_num = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      drop_num = drop_num + DROP_W'(drop[i]);
    end
  end

  assign ovf_sum = 17'(ovf_cnt_q) + 17'(drop_num);

  // Saturating count; a clear takes priority over drops seen in the same cycle.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i || ovf_clr_i) begin
      ovf_cnt_q <= '0;
    end else if (ovf_sum[16]) begin
      ovf_cnt_q <= 16'hFFFF;
    end else begin
      ovf_cnt_q <= ovf_sum[15:0];
    end
  end

  assign ovf_cnt_o = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_io_event_queue.sv
// Bench for io_event_queue: directed scenarios plus random traffic against a queue-based model.
module tb_io_event_queue;

  localparam int NS = 32;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic [NS-1:0] evt_src;
  logic          ready;
  logic          ev_valid;
  logic [7:0]    ev_data;
  logic          ovf;
  logic [NS-1:0] src_b;
  logic          b_valid;
  logic [7:0]    b_data;
  logic          b_ovf;
`ifdef EVT_OVF_CNT_EN
  logic [15:0]   ovf_cnt;
  logic          ovf_clr;
  logic [15:0]   b_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Model state: pending flags, search start, queued IDs, overflow flag, drop count.
  bit m_pend[NS];
  int m_rr;
  int m_q[$];
  bit m_ovf;
  int m_cnt;

  always #5 clk = ~clk;

  io_event_queue #(.NUM_SRC(NS), .DEPTH(DP), .SRC_ID_BASE(8'h00)) dut (
    .sys_clk_i     (clk),
    .sys_rst_i     (sys_rst),
    .evt_src_i     (evt_src),
    .event_valid_o (ev_valid),
    .event_data_o  (ev_data),
    .event_ready_i (ready),
    .overflow_o    (ovf)
`ifdef EVT_OVF_CNT_EN
    ,
    .ovf_cnt_o     (ovf_cnt),
    .ovf_clr_i     (ovf_clr)
`endif
  );

  io_event_queue #(.NUM_SRC(NS), .DEPTH(DP), .SRC_ID_BASE(8'hF0)) dut_b (
    .sys_clk_i     (clk),
    .sys_rst_i     (sys_rst),
    .evt_src_i     (src_b),
    .event_valid_o (b_valid),
    .event_data_o  (b_data),
    .event_ready_i (1'b1),
    .overflow_o    (b_ovf)
`ifdef EVT_OVF_CNT_EN
    ,
    .ovf_cnt_o     (b_cnt),
    .ovf_clr_i     (1'b0)
`endif
  );

  task automatic model_step(input logic [NS-1:0] src, input bit rdy, input bit rst, input bit clr);
    int g;
    int nd;
    if (rst) begin
      foreach (m_pend[k]) m_pend[k] = 1'b0;
      m_q.delete();
      m_rr  = 0;
      m_ovf = 1'b0;
      m_cnt = 0;
      return;
    end
    g  = -1;
    nd = 0;
    if (m_q.size() < DP) begin
      for (int i = 0; i < NS; i++) begin
        if (m_pend[(m_rr + i) % NS]) begin
          g = (m_rr + i) % NS;
          break;
        end
      end
    end
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(g);
      m_pend[g] = 1'b0;
      m_rr = (g + 1) % NS;
    end
    for (int k = 0; k < NS; k++) begin
      if (src[k]) begin
        if (m_pend[k]) nd++;
        m_pend[k] = 1'b1;
      end
    end
    m_ovf = (nd > 0);
    if (clr) m_cnt = 0;
    else m_cnt = (m_cnt + nd > 65535) ? 65535 : m_cnt + nd;
  endtask

  // Applies one cycle of inputs, advances the model at the edge, returns 1 time unit later.
  task automatic cycle(input logic [NS-1:0] src, input bit rdy, input bit rst, input bit clr);
    evt_src = src;
    ready   = rdy;
    sys_rst = rst;
`ifdef EVT_OVF_CNT_EN
    ovf_clr = clr;
`endif
    @(posedge clk);
    model_step(src, rdy, rst, clr);
    #1;
    evt_src = '0;
    sys_rst = 1'b0;
`ifdef EVT_OVF_CNT_EN
    ovf_clr = 1'b0;
`endif
  endtask

  task automatic test_reset();
    cycle('0, 1'b0, 1'b1, 1'b0);
    cycle('0, 1'b0, 1'b1, 1'b0);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ev_valid); end
    total++; if (ev_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", ev_data); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", ovf); end
    total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL reset_b_valid got=%b want=0", b_valid); end
`ifdef EVT_OVF_CNT_EN
    total++; if (ovf_cnt !== 16'h0) begin bad++; $display("FAIL reset_ovf_cnt got=%h want=0000", ovf_cnt); end
`endif
  endtask

  task automatic test_single();
    cycle(32'h0000_0008, 1'b1, 1'b0, 1'b0);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL single_c1_valid got=%b want=0", ev_valid); end
    cycle('0, 1'b1, 1'b0, 1'b0);
    total++;
    if (ev_valid !== 1'b1 || ev_data !== 8'h03) begin
      bad++; $display("FAIL single_c2 got valid=%b data=%h want valid=1 data=03", ev_valid, ev_data);
    end
    cycle('0, 1'b1, 1'b0, 1'b0);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL single_c3_valid got=%b want=0", ev_valid); end
  endtask

  task automatic test_multi();
    logic [7:0] exp_a [3];
    logic [7:0] exp_b [2];
    exp_a = '{8'h00, 8'h05, 8'h1F};
    exp_b = '{8'h00, 8'h1F};
    cycle('0, 1'b0, 1'b1, 1'b0);
    cycle(32'h8000_0021, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle('0, 1'b1, 1'b0, 1'b0);
      total++;
      if (ev_valid !== 1'b1 || ev_data !== exp_a[i]) begin
        bad++; $display("FAIL multi_order[%0d] got valid=%b data=%h want valid=1 data=%h", i, ev_valid, ev_data, exp_a[i]);
      end
    end
    cycle('0, 1'b1, 1'b0, 1'b0);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL multi_tail_valid got=%b want=0", ev_valid); end
    // Search restarts at source 0, so 0 must beat 31.
    cycle(32'h8000_0001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle('0, 1'b1, 1'b0, 1'b0);
      total++;
      if (ev_valid !== 1'b1 || ev_data !== exp_b[i]) begin
        bad++; $display("FAIL multi_rr[%0d] got valid=%b data=%h want valid=1 data=%h", i, ev_valid, ev_data, exp_b[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int got[$];
    bit seen_ovf;
    seen_ovf = 1'b0;
    cycle('0, 1'b0, 1'b1, 1'b0);
    cycle(32'h0000_07FE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cycle('0, 1'b0, 1'b0, 1'b0);
      if (ovf === 1'b1) seen_ovf = 1'b1;
    end
    total++;
    if (ev_valid !== 1'b1 || ev_data !== 8'h01) begin
      bad++; $display("FAIL bp_head got valid=%b data=%h want valid=1 data=01", ev_valid, ev_data);
    end
    total++; if (seen_ovf) begin bad++; $display("FAIL bp_no_overflow got=1 want=0"); end
    for (int i = 0; i < 30; i++) begin
      if (ev_valid === 1'b1) got.push_back(int'(ev_data));
      cycle('0, 1'b1, 1'b0, 1'b0);
    end
    total++; if (got.size() != 10) begin bad++; $display("FAIL bp_count got=%0d want=10", got.size()); end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      total++; if (got[i] != i + 1) begin bad++; $display("FAIL bp_id[%0d] got=%0d want=%0d", i, got[i], i + 1); end
    end
  endtask

  task automatic test_overflow();
    int got[$];
    int exp_ids[9];
    exp_ids = '{8, 9, 10, 11, 12, 13, 14, 15, 2};
    cycle('0, 1'b0, 1'b1, 1'b0);
    cycle(32'h0000_FF00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle('0, 1'b0, 1'b0, 1'b0);
    cycle(32'h0000_0004, 1'b0, 1'b0, 1'b0);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_first_pulse got=%b want=0", ovf); end
    for (int i = 0; i < 2; i++) begin
      cycle('0, 1'b0, 1'b0, 1'b0);
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_gap[%0d] got=%b want=0", i, ovf); end
    end
    cycle(32'h0000_0004, 1'b0, 1'b0, 1'b0);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b want=1", ovf); end
`ifdef EVT_OVF_CNT_EN
    total++; if (ovf_cnt !== 16'd1) begin bad++; $display("FAIL ovf_cnt_one got=%0d want=1", ovf_cnt); end
`endif
    cycle('0, 1'b0, 1'b0, 1'b0);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_single_cycle got=%b want=0", ovf); end
`ifdef EVT_OVF_CNT_EN
    cycle('0, 1'b0, 1'b0, 1'b1);
    total++; if (ovf_cnt !== 16'd0) begin bad++; $display("FAIL ovf_cnt_clear got=%0d want=0", ovf_cnt); end
`endif
    for (int i = 0; i < 30; i++) begin
      if (ev_valid === 1'b1) got.push_back(int'(ev_data));
      cycle('0, 1'b1, 1'b0, 1'b0);
    end
    total++; if (got.size() != 9) begin bad++; $display("FAIL ovf_drain_count got=%0d want=9", got.size()); end
    for (int i = 0; i < got.size() && i < 9; i++) begin
      total++;
      if (got[i] != exp_ids[i]) begin bad++; $display("FAIL ovf_drain_id[%0d] got=%0d want=%0d", i, got[i], exp_ids[i]); end
    end
  endtask

  task automatic test_base();
    src_b = 32'h0010_0000;
    cycle('0, 1'b0, 1'b0, 1'b0);
    src_b = '0;
    cycle('0, 1'b0, 1'b0, 1'b0);
    total++;
    if (b_valid !== 1'b1 || b_data !== 8'h04) begin
      bad++; $display("FAIL base_wrap got valid=%b data=%h want valid=1 data=04", b_valid, b_data);
    end
    cycle('0, 1'b0, 1'b0, 1'b0);
    src_b = 32'h0000_8000;
    cycle('0, 1'b0, 1'b0, 1'b0);
    src_b = '0;
    cycle('0, 1'b0, 1'b0, 1'b0);
    total++;
    if (b_valid !== 1'b1 || b_data !== 8'hFF) begin
      bad++; $display("FAIL base_top got valid=%b data=%h want valid=1 data=ff", b_valid, b_data);
    end
    total++; if (b_ovf !== 1'b0) begin bad++; $display("FAIL base_overflow got=%b want=0", b_ovf); end
`ifdef EVT_OVF_CNT_EN
    total++; if (b_cnt !== 16'd0) begin bad++; $display("FAIL base_cnt got=%0d want=0", b_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    cycle('0, 1'b0, 1'b1, 1'b0);
    cycle(32'h0000_001F, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle('0, 1'b0, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0, 1'b0);
    total++;
    if (ev_valid !== 1'b1 || ev_data !== 8'h02) begin
      bad++; $display("FAIL mid_head got valid=%b data=%h want valid=1 data=02", ev_valid, ev_data);
    end
    cycle(32'h000F_0000, 1'b1, 1'b1, 1'b0);
    total++;
    if (ev_valid !== 1'b0 || ev_data !== 8'h00) begin
      bad++; $display("FAIL mid_after_reset got valid=%b data=%h want valid=0 data=00", ev_valid, ev_data);
    end
    for (int i = 0; i < 6; i++) begin
      cycle('0, 1'b1, 1'b0, 1'b0);
      total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL mid_stale[%0d] got valid=%b data=%h want valid=0", i, ev_valid, ev_data); end
    end
  endtask

  task automatic test_random();
    logic [NS-1:0] s;
    bit r;
    bit rs;
    bit c;
    logic [7:0] want;
    cycle('0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 800; n++) begin
      s  = ($urandom_range(0, 1) == 0) ? '0 : NS'($urandom & $urandom & $urandom & $urandom);
      r  = ($urandom_range(0, 3) != 0) && (((n / 64) % 2) == 0 || $urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 299) == 0);
      c  = ($urandom_range(0, 15) == 0);
      cycle(s, r, rs, c);
      want = (m_q.size() != 0) ? 8'(m_q[0]) : 8'h00;
      total++; if (ev_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", n, ev_valid, m_q.size() != 0); end
      total++; if (ev_data !== want) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", n, ev_data, want); end
      total++; if (ovf !== m_ovf) begin bad++; $display("FAIL rnd_overflow cyc=%0d got=%b want=%b", n, ovf, m_ovf); end
`ifdef EVT_OVF_CNT_EN
      total++; if (ovf_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL rnd_ovf_cnt cyc=%0d got=%0d want=%0d", n, ovf_cnt, m_cnt); end
`endif
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    evt_src = '0;
    src_b   = '0;
    ready   = 1'b0;
`ifdef EVT_OVF_CNT_EN
    ovf_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_overflow();
    test_base();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
